// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared definitions for the sprite motion controller and the
//               pixel-stage overlay compare. Holds the visible area, sprite
//               size, direction bit indices and controller state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    // Visible area and sprite footprint defaults
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int SPR_W = 20;
    localparam int SPR_H = 20;

    // Bit positions inside the packed button vector {down, up, right, left}
    localparam int DIR_L = 0;
    localparam int DIR_R = 1;
    localparam int DIR_U = 2;
    localparam int DIR_D = 3;

    // One-hot frame-update controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'b001;
    localparam state_t ST_ARMED  = 3'b010;
    localparam state_t ST_UPDATE = 3'b100;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser followed by a stability counter. The
//               debounced level only follows the synchronised input once the
//               two have disagreed for DEBOUNCE_CYC consecutive cycles; a
//               single agreeing cycle restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_db
);

    localparam int c_CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_db;

    // Bring the raw, asynchronous button level into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (r_sync[1] != r_db) begin
            if (r_cnt == c_CNT_LAST) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_db = r_db;

endmodule
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sprite_motion_ctrl
// Description : Turns four raw direction buttons into a frame-synchronous,
//               clamped sprite position for the pixel-stage overlay. Each
//               button is synchronised and debounced; the position moves at
//               most once per frame, on the falling edge of vertical sync.
//               Optional feature macro: SPRITE_ACCEL_EN - when defined, the
//               step size grows while a direction stays held.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_ctrl #(
    parameter int H_ACT        = sprite_pkg::H_ACT,
    parameter int V_ACT        = sprite_pkg::V_ACT,
    parameter int SPR_W        = sprite_pkg::SPR_W,
    parameter int SPR_H        = sprite_pkg::SPR_H,
    parameter int X_INIT       = 310,
    parameter int Y_INIT       = 230,
    parameter int STEP         = 1,
    parameter int DEBOUNCE_CYC = 250000
`ifdef SPRITE_ACCEL_EN
    ,
    parameter int MAX_STEP     = 8,
    parameter int ACCEL_FRAMES = 8
`endif
) (
    input  logic       iVGA_CLK,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       iVS,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       moving,
    output logic       edge_hit,
    output logic [3:0] btn_db
);

    import sprite_pkg::*;

    localparam logic signed [10:0] c_X_LIM  = 11'(H_ACT - SPR_W);
    localparam logic signed [10:0] c_Y_LIM  = 11'(V_ACT - SPR_H);
    localparam logic [9:0]         c_X_INIT = 10'(X_INIT);
    localparam logic [9:0]         c_Y_INIT = 10'(Y_INIT);
    localparam logic [9:0]         c_STEP   = 10'(STEP);

    logic [3:0]         w_btn_raw;
    logic [3:0]         w_btn_db;
    logic               r_vs_q;
    logic               w_tick;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_do_update;
    logic [9:0]         w_spd;
    logic signed [10:0] w_spd_s;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic signed [10:0] w_x_sum;
    logic signed [10:0] w_y_sum;
    logic [9:0]         w_x_new;
    logic [9:0]         w_y_new;
    logic               w_x_clip;
    logic               w_y_clip;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_moving;
    logic               r_edge_hit;

    // Pack the raw buttons by direction index
    always_comb begin
        w_btn_raw        = '0;
        w_btn_raw[DIR_L] = left;
        w_btn_raw[DIR_R] = right;
        w_btn_raw[DIR_U] = up;
        w_btn_raw[DIR_D] = down;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_btn_debounce (
            .clk   (iVGA_CLK),
            .rst   (reset),
            .i_btn (w_btn_raw[gi]),
            .o_db  (w_btn_db[gi])
        );
    end

    // Delayed copy of vertical sync for falling-edge detection
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            r_vs_q <= 1'b0;
        end else begin
            r_vs_q <= iVS;
        end
    end

    assign w_tick = r_vs_q & ~iVS;

    // Controller state register
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Re-arm only after sync has been seen high again, so a burst of sync
    // glitches inside one frame still produces a single update
    always_comb begin
        w_state_nxt = r_state;
        w_do_update = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iVS) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_tick) begin
                    w_state_nxt = ST_UPDATE;
                    w_do_update = 1'b1;
                end
            end
            ST_UPDATE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef SPRITE_ACCEL_EN
    localparam int c_FCNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(ACCEL_FRAMES - 1);
    localparam logic [9:0]          c_MAX_STEP  = 10'(MAX_STEP);

    logic [9:0]          r_spd;
    logic [c_FCNT_W-1:0] r_frame_cnt;

    // Speed ramps up every ACCEL_FRAMES held updates; any idle update drops it back
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            r_spd       <= c_STEP;
            r_frame_cnt <= '0;
        end else if (w_do_update) begin
            if (|w_btn_db) begin
                if (r_frame_cnt == c_FCNT_LAST) begin
                    r_frame_cnt <= '0;
                    if (r_spd < c_MAX_STEP) begin
                        r_spd <= r_spd + 10'd1;
                    end
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_FCNT_W'(1);
                end
            end else begin
                r_spd       <= c_STEP;
                r_frame_cnt <= '0;
            end
        end
    end

    assign w_spd = r_spd;
`else
    assign w_spd = c_STEP;
`endif

    // Per-axis displacement and clamping; opposite buttons on one axis cancel
    always_comb begin
        w_spd_s  = $signed({1'b0, w_spd});
        w_dx     = '0;
        w_dy     = '0;
        if (w_btn_db[DIR_R] && !w_btn_db[DIR_L]) begin
            w_dx = w_spd_s;
        end else if (w_btn_db[DIR_L] && !w_btn_db[DIR_R]) begin
            w_dx = -w_spd_s;
        end
        if (w_btn_db[DIR_D] && !w_btn_db[DIR_U]) begin
            w_dy = w_spd_s;
        end else if (w_btn_db[DIR_U] && !w_btn_db[DIR_D]) begin
            w_dy = -w_spd_s;
        end

        w_x_sum  = $signed({1'b0, r_x}) + w_dx;
        w_y_sum  = $signed({1'b0, r_y}) + w_dy;

        w_x_new  = w_x_sum[9:0];
        w_x_clip = 1'b0;
        if (w_x_sum[10]) begin
            w_x_new  = '0;
            w_x_clip = 1'b1;
        end else if (w_x_sum > c_X_LIM) begin
            w_x_new  = c_X_LIM[9:0];
            w_x_clip = 1'b1;
        end

        w_y_new  = w_y_sum[9:0];
        w_y_clip = 1'b0;
        if (w_y_sum[10]) begin
            w_y_new  = '0;
            w_y_clip = 1'b1;
        end else if (w_y_sum > c_Y_LIM) begin
            w_y_new  = c_Y_LIM[9:0];
            w_y_clip = 1'b1;
        end
    end

    // Position and status only change on the update cycle; edge_hit is a single-cycle pulse
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            r_x        <= c_X_INIT;
            r_y        <= c_Y_INIT;
            r_moving   <= 1'b0;
            r_edge_hit <= 1'b0;
        end else begin
            r_edge_hit <= 1'b0;
            if (w_do_update) begin
                r_x        <= w_x_new;
                r_y        <= w_y_new;
                r_moving   <= (w_x_new != r_x) || (w_y_new != r_y);
                r_edge_hit <= w_x_clip | w_y_clip;
            end
        end
    end

    assign sprite_x = r_x;
    assign sprite_y = r_y;
    assign moving   = r_moving;
    assign edge_hit = r_edge_hit;
    assign btn_db   = w_btn_db;

endmodule
`default_nettype wire
